dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
  DEPTH_WORDS, 1024, number of 32-bit storage words (power of two).
  WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk  in  1  the single clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  req_valid  in  1  memory stage presents a request.
  req_ready  out  1  responder can accept a request.
  req_we  in  1  1 = write, 0 = read.
  req_addr  in  32  byte address.
  req_wdata  in  32  write data.
  req_be  in  4  byte enables; bit i enables byte lane i.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  memory stage consumes the response.
  rsp_rdata  out  32  read data; 0 for writes and errors.
  rsp_err  out  1  request was misaligned or out of range.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on any edge where req_valid and req_ready are both 1, latching we/addr/wdata/be.
REQ-005 On acceptance the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise directly to RESP.
REQ-006 WAIT SHALL load a down-counter with WAIT_STATES-1 and transition to RESP on the edge where the counter equals 0.
REQ-007 rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge and SHALL hold, with rsp_rdata/rsp_err stable, until the edge where rsp_ready=1, which SHALL return the FSM to IDLE.
REQ-008 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-009 A request with addr[1:0]!=0 SHALL complete with rsp_err=1, rsp_rdata=0 and no storage change.
REQ-010 A write SHALL update only the byte lanes enabled by req_be, on the edge entering RESP; be=0 SHALL complete with rsp_err=0 and no change.
REQ-011 Read data SHALL be the full word as stored at the edge entering RESP; req_be SHALL be ignored for reads.
REQ-012 A read following a write to the same word SHALL return the written data.
REQ-013 req_valid SHALL be ignored outside IDLE; at most one request SHALL be outstanding.

Reset
REQ-014 While rst=1 at an edge the FSM SHALL enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the counter at 0.
REQ-015 Reset in WAIT SHALL drop the request without performing its write; reset in RESP SHALL drop the pending response.
REQ-016 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-017 With DMEM_RANGE_CHECK_EN defined, any address with a bit set above bit log2(DEPTH_WORDS)+1 SHALL complete with rsp_err=1, rsp_rdata=0 and no write.
REQ-018 Without DMEM_RANGE_CHECK_EN, upper address bits SHALL be ignored and addresses SHALL alias modulo DEPTH_WORDS*4.

Structure
REQ-019 Package dmem_pkg SHALL hold the FSM state enum, the default DEPTH_WORDS and WAIT_STATES constants, and the counter width constant.
REQ-020 Storage SHALL be a sub-module dmem_array with a single port, synchronous read, and per-byte write enables.

Verification
REQ-021 WAIT_STATES=1: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> each rsp_valid 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-022 Write 0x11223344 to 0x20 with be=0x2 over stored 0 -> read returns 0x00003300.
REQ-023 Read 0x13 -> rsp_err=1, rdata=0, storage unchanged.
REQ-024 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0, new req_valid ignored.
REQ-025 Assert rst during WAIT of a write to 0x40 -> IDLE next cycle, subsequent read of 0x40 returns the old value.
REQ-026 Read 0x1000 (DEPTH_WORDS=1024) -> with the macro, err=1; without it, returns the word at 0x0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default sizing and address-error helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_WAIT_STATES = 1;
    localparam int CNT_W           = 4;

    // Misaligned always errors; the upper-bit check only counts when range_chk is set.
    function automatic logic addr_err(input logic [31:0] addr, input int aw, input logic range_chk);
        logic misaligned_s;
        logic above_s;
        misaligned_s = (addr[1:0] != 2'b00);
        above_s      = ((addr >> (aw + 2)) != 32'd0);
        return misaligned_s | (range_chk & above_s);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous read and per-byte write enables.
// Read returns the contents before any write on the same edge; no reset on storage.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles, then holds a response.
// Optional macro DMEM_RANGE_CHECK_EN flags addresses above the storage range as errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};
`ifdef DMEM_RANGE_CHECK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             req_ready_r;
    logic             lat_we_r;
    logic [31:0]      lat_addr_r;
    logic [31:0]      lat_wdata_r;
    logic [3:0]       lat_be_r;
    logic             acc_err_r;
    logic             acc_we_r;
    logic             rsp_valid_r;
    logic             rsp_err_r;
    logic [31:0]      rsp_rdata_r;

    logic             accept_s;
    logic             enter_resp_s;
    logic             acc_we_s;
    logic [31:0]      acc_addr_s;
    logic [31:0]      acc_wdata_s;
    logic [3:0]       acc_be_s;
    logic             acc_err_s;
    logic [3:0]       mem_we_s;
    logic [31:0]      mem_rdata_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);

    // Next-state decision for the request/wait/response sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, so use live inputs in IDLE.
    always_comb begin
        acc_we_s    = lat_we_r;
        acc_addr_s  = lat_addr_r;
        acc_wdata_s = lat_wdata_r;
        acc_be_s    = lat_be_r;
        if (state_r == ST_IDLE) begin
            acc_we_s    = req_we;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
        end else begin
            acc_we_s    = lat_we_r;
            acc_addr_s  = lat_addr_r;
            acc_wdata_s = lat_wdata_r;
            acc_be_s    = lat_be_r;
        end
        acc_err_s    = addr_err(acc_addr_s, AW, RANGE_CHK);
        enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP) && !rst;
        if (enter_resp_s && acc_we_s && !acc_err_s) begin
            mem_we_s = acc_be_s;
        end else begin
            mem_we_s = 4'b0000;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp_s),
        .we    (mem_we_s),
        .addr  (acc_addr_s[AW+1:2]),
        .wdata (acc_wdata_s),
        .rdata (mem_rdata_s)
    );

    // State register, wait counter and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
            lat_be_r    <= 4'b0000;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                cnt_r       <= WAIT_LOAD;
                lat_we_r    <= req_we;
                lat_addr_r  <= req_addr;
                lat_wdata_r <= req_wdata;
                lat_be_r    <= req_be;
            end else if ((state_r == ST_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // Response registers: captured one cycle after the access, cleared on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_err_r   <= 1'b0;
            acc_we_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
        end else begin
            if (enter_resp_s) begin
                acc_err_r <= acc_err_s;
                acc_we_r  <= acc_we_s;
            end
            if ((state_r == ST_RESP) && !rsp_valid_r) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= acc_err_r;
                rsp_rdata_r <= (acc_err_r || acc_we_r) ? 32'd0 : mem_rdata_s;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 32'd0;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of transactions plus stall/reset sequences.
module tb_dmem_responder;

    localparam int WS = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[20];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    task automatic wait_rsp(input int id, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL step%0d rsp_timeout: got no rsp_valid expected one within 20 cycles", id);
        end
    endtask

    task automatic txn(input int id, input vec_t v);
        int lat;
        @(negedge clk);
        chk(id, "req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(id, lat);
        chk(id, "latency", 32'(lat), 32'(WS + 1));
        chk(id, "rdata", rsp_rdata, v.exp_rdata);
        chk(id, "err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk(id, "rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
        chk(id, "req_ready_done", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        vec_t v;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,   32'h0,        4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,   32'h11223344, 4'h2, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h00003300, 1'b0};
        vecs[5]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 32'h13,   32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{1'b1, 32'h10,   32'h0,        4'h0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b1, 32'h24,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 32'h24,   32'hA1B2C3D4, 4'h5, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 32'h24,   32'h0,        4'h1, 32'hFFB2FFD4, 1'b0};
        vecs[15] = '{1'b1, 32'h40,   32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 32'h40,   32'h0,        4'hF, 32'h12345678, 1'b0};
`ifdef DMEM_RANGE_CHECK_EN
        vecs[17] = '{1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[18] = '{1'b1, 32'h1000, 32'h77777777, 4'hF, 32'h0,        1'b1};
        vecs[19] = '{1'b0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
`else
        vecs[17] = '{1'b0, 32'h1000, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[18] = '{1'b1, 32'h1000, 32'h77777777, 4'hF, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 32'h0,    32'h0,        4'hF, 32'h77777777, 1'b0};
`endif

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_be = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk(0, "rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk(0, "rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk(0, "rst_rdata", rsp_rdata, 32'd0);
        chk(0, "rst_err", {31'd0, rsp_err}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            txn(i + 1, vecs[i]);
        end

        // Stalled response: outputs hold and a new request is ignored.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'hF;
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hBAD0BAD0;
        wait_rsp(30, lat);
        for (int i = 0; i < 5; i++) begin
            chk(30 + i, "stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk(30 + i, "stall_rdata", rsp_rdata, 32'hDEADBEEF);
            chk(30 + i, "stall_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(40 + i, "no_extra_rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        v = '{1'b0, 32'h20, 32'h0, 4'hF, 32'h00003300, 1'b0};
        txn(45, v);

        // Reset during WAIT of a write drops the write.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h0BADF00D;
        req_be    = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(50, "wait_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk(50, "wait_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk(51, "wait_rst_quiet", {31'd0, rsp_valid}, 32'd0);
        end
        v = '{1'b0, 32'h40, 32'h0, 4'hF, 32'h12345678, 1'b0};
        txn(52, v);

        // Reset while a response is pending drops it.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(60, lat);
        chk(60, "pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(61, "resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk(61, "resp_rst_rdata", rsp_rdata, 32'd0);
        chk(61, "resp_rst_req_ready", {31'd0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
